// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB receive sequencer (sync gate, NRZI decode, unstuff, EOP).
// Optional babble limit enabled by defining USB_RX_BABBLE_CHECK_EN.
module usb_rx_ctrl #(
    parameter int MAX_BYTES = 1027,
    parameter int IDLE_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_strobe,
    input  logic [1:0]  line_state,
    input  logic        rx_enable,
    input  logic        sync_detected,
    output logic        det_reset,
    output logic        rx_active,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_done,
    output logic        rx_error,
    output logic [1:0]  rx_err_code,
    output logic [10:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_DATA,
        S_EOP,
        S_ABORT
    } state_t;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

    state_t          r_state;
    logic [1:0]      r_prev;
    logic [2:0]      r_ones;
    logic [2:0]      r_bits;
    logic [7:0]      r_shift;
    logic [1:0]      r_se0;
    logic [IW-1:0]   r_idle;
    logic            r_det;
    logic            r_active;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_done;
    logic            r_error;
    logic [1:0]      r_code;
    logic [10:0]     r_count;

    logic            w_bit;
    logic [7:0]      w_byte;
    logic            w_babble;

    // NRZI: no transition means a 1; byte assembles LSB first from the top.
    assign w_bit  = (line_state == r_prev);
    assign w_byte = {w_bit, r_shift[7:1]};

`ifdef USB_RX_BABBLE_CHECK_EN
    assign w_babble = (r_count == 11'(MAX_BYTES));
`else
    assign w_babble = 1'b0;
`endif

    // Main sequencer; pulses default low and last exactly one clock.
    always_ff @(posedge clk) begin
        r_valid <= 1'b0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
        if (reset) begin
            r_state  <= S_IDLE;
            r_prev   <= LS_K;
            r_ones   <= '0;
            r_bits   <= '0;
            r_shift  <= '0;
            r_se0    <= '0;
            r_idle   <= '0;
            r_det    <= 1'b1;
            r_active <= 1'b0;
            r_data   <= '0;
            r_code   <= '0;
            r_count  <= '0;
        end else if (!rx_enable) begin
            r_state  <= S_IDLE;
            r_det    <= 1'b1;
            r_active <= 1'b0;
        end else if (bit_strobe) begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_WAIT_SYNC;
                    r_det   <= 1'b0;
                end
                S_WAIT_SYNC: begin
                    if (sync_detected) begin
                        r_state  <= S_DATA;
                        r_active <= 1'b1;
                        r_prev   <= LS_K;
                        r_ones   <= '0;
                        r_bits   <= '0;
                        r_count  <= '0;
                        r_code   <= '0;
                    end
                end
                S_DATA: begin
                    if (line_state == LS_SE0) begin
                        r_state <= S_EOP;
                        r_se0   <= 2'd1;
                    end else if (line_state == LS_SE1) begin
                        r_state  <= S_ABORT;
                        r_det    <= 1'b1;
                        r_active <= 1'b0;
                        r_error  <= 1'b1;
                        r_code   <= 2'b10;
                        r_idle   <= '0;
                    end else begin
                        r_prev <= line_state;
                        if (r_ones == 3'd6) begin
                            if (w_bit) begin
                                r_state  <= S_ABORT;
                                r_det    <= 1'b1;
                                r_active <= 1'b0;
                                r_error  <= 1'b1;
                                r_code   <= 2'b01;
                                r_idle   <= '0;
                            end else begin
                                r_ones <= '0;
                            end
                        end else begin
                            r_shift <= w_byte;
                            r_ones  <= w_bit ? r_ones + 3'd1 : 3'd0;
                            r_bits  <= r_bits + 3'd1;
                            if (r_bits == 3'd7) begin
                                if (w_babble) begin
                                    r_state  <= S_ABORT;
                                    r_det    <= 1'b1;
                                    r_active <= 1'b0;
                                    r_error  <= 1'b1;
                                    r_code   <= 2'b11;
                                    r_idle   <= '0;
                                end else begin
                                    r_data  <= w_byte;
                                    r_valid <= 1'b1;
                                    if (r_count != 11'h7FF)
                                        r_count <= r_count + 11'd1;
                                end
                            end
                        end
                    end
                end
                S_EOP: begin
                    if (line_state == LS_SE0) begin
                        if (r_se0 != 2'd3)
                            r_se0 <= r_se0 + 2'd1;
                    end else if (line_state == LS_J &&
                                 r_se0 >= 2'd2 && r_bits == 3'd0) begin
                        r_state  <= S_IDLE;
                        r_det    <= 1'b1;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_state  <= S_ABORT;
                        r_det    <= 1'b1;
                        r_active <= 1'b0;
                        r_error  <= 1'b1;
                        r_code   <= 2'b10;
                        r_idle   <= '0;
                    end
                end
                S_ABORT: begin
                    if (line_state == LS_J) begin
                        if (r_idle == IDLE_LAST) begin
                            r_state <= S_IDLE;
                            r_idle  <= '0;
                        end else begin
                            r_idle <= r_idle + 1'b1;
                        end
                    end else begin
                        r_idle <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_det   <= 1'b1;
                end
            endcase
        end
    end

    assign det_reset   = r_det;
    assign rx_active   = r_active;
    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign rx_done     = r_done;
    assign rx_error    = r_error;
    assign rx_err_code = r_code;
    assign byte_count  = r_count;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed stimulus with an event scoreboard for usb_rx_ctrl.
// Expected pulses are queued by the driver and consumed by the monitor.
module tb_usb_rx_ctrl;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;
    localparam logic [1:0] SE1 = 2'b11;

    localparam logic [1:0] EV_VALID = 2'd1;
    localparam logic [1:0] EV_DONE  = 2'd2;
    localparam logic [1:0] EV_ERROR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  data;
        logic [1:0]  code;
        logic [10:0] cnt;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_strobe = 1'b0;
    logic [1:0]  line_state = J;
    logic        rx_enable = 1'b0;
    logic        sync_detected = 1'b0;
    logic        det_reset;
    logic        rx_active;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_done;
    logic        rx_error;
    logic [1:0]  rx_err_code;
    logic [10:0] byte_count;

    int n_pass = 0;
    int n_total = 0;
    ev_t sb[$];
    logic [1:0] tb_lvl;
    int tb_ones;

    usb_rx_ctrl #(
`ifdef USB_RX_BABBLE_CHECK_EN
        .MAX_BYTES(4),
`else
        .MAX_BYTES(1027),
`endif
        .IDLE_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bit_strobe(bit_strobe),
        .line_state(line_state),
        .rx_enable(rx_enable),
        .sync_detected(sync_detected),
        .det_reset(det_reset),
        .rx_active(rx_active),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_done(rx_done),
        .rx_error(rx_error),
        .rx_err_code(rx_err_code),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [7:0] d,
                               input logic [1:0] c, input logic [10:0] n);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.code = c;
        e.cnt  = n;
        return e;
    endfunction

    function automatic logic [1:0] tgl(input logic [1:0] l);
        return (l == J) ? K : J;
    endfunction

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (rx_valid || rx_done || rx_error)) begin
            ev_t e;
            logic [1:0] k;
            if (32'(rx_valid) + 32'(rx_done) + 32'(rx_error) > 1)
                check("pulse_excl", {rx_valid, rx_done, rx_error}, 0);
            k = rx_valid ? EV_VALID : (rx_done ? EV_DONE : EV_ERROR);
            if (sb.size() == 0) begin
                check("unexpected_pulse", k, 0);
            end else begin
                e = sb.pop_front();
                check("ev_kind", k, e.kind);
                if (e.kind == EV_VALID) begin
                    check("rx_data", rx_data, e.data);
                    check("byte_count", byte_count, e.cnt);
                end
                if (e.kind == EV_ERROR)
                    check("err_code", rx_err_code, e.code);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] ls);
        bit_strobe = 1'b1;
        line_state = ls;
        cyc();
        bit_strobe = 1'b0;
        cyc();
    endtask

    task automatic start_pkt();
        strobe(J);
        sync_detected = 1'b1;
        strobe(K);
        sync_detected = 1'b0;
        tb_lvl = K;
        tb_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit nostuff);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) tb_ones++;
            else begin
                tb_ones = 0;
                tb_lvl = tgl(tb_lvl);
            end
            strobe(tb_lvl);
            if (tb_ones == 6 && !nostuff) begin
                tb_lvl = tgl(tb_lvl);
                strobe(tb_lvl);
                tb_ones = 0;
            end
        end
    endtask

    task automatic recover();
        repeat (8) strobe(J);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_det"}, det_reset, 1);
        check({tag, "_act"}, rx_active, 0);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_done"}, rx_done, 0);
        check({tag, "_err"}, rx_error, 0);
        check({tag, "_code"}, rx_err_code, 0);
        check({tag, "_cnt"}, byte_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        check_reset_vals("rst");
        reset = 1'b0;
        rx_enable = 1'b1;
        cyc();

        // Basic packet 0xA5 with clean EOP.
        start_pkt();
        check("a5_active", rx_active, 1);
        check("a5_det", det_reset, 0);
        sb.push_back(mk(EV_VALID, 8'hA5, 0, 11'd1));
        strobe(K); strobe(J); strobe(J); strobe(K);
        strobe(J); strobe(J); strobe(K); strobe(K);
        sb.push_back(mk(EV_DONE, 0, 0, 0));
        strobe(SE0);
        strobe(SE0);
        check("a5_eop_active", rx_active, 1);
        strobe(J);
        check("a5_end_active", rx_active, 0);
        check("a5_end_det", det_reset, 1);
        check("a5_end_cnt", byte_count, 1);

        // 0xFF then 0x00 with a stuffed bit.
        start_pkt();
        sb.push_back(mk(EV_VALID, 8'hFF, 0, 11'd1));
        sb.push_back(mk(EV_VALID, 8'h00, 0, 11'd2));
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back(mk(EV_DONE, 0, 0, 0));
        strobe(SE0); strobe(SE0); strobe(J);
        check("ff00_cnt", byte_count, 2);

        // Missing stuff bit.
        start_pkt();
        sb.push_back(mk(EV_ERROR, 0, 2'b01, 0));
        send_byte(8'hFF, 1'b1);
        check("stuff_code", rx_err_code, 2'b01);
        check("stuff_det", det_reset, 1);
        check("stuff_active", rx_active, 0);
        recover();

        // SE1 mid-byte, then idle recovery boundary.
        start_pkt();
        strobe(K); strobe(K); strobe(J);
        sb.push_back(mk(EV_ERROR, 0, 2'b10, 0));
        strobe(SE1);
        check("se1_code", rx_err_code, 2'b10);
        repeat (7) strobe(J);
        check("idle7_det", det_reset, 1);
        strobe(J);
        check("idle8_det", det_reset, 1);
        strobe(J);
        check("wait_det", det_reset, 0);

        // Misaligned EOP after 3 bits.
        start_pkt();
        strobe(K); strobe(K); strobe(K);
        sb.push_back(mk(EV_ERROR, 0, 2'b10, 0));
        strobe(SE0); strobe(SE0); strobe(J);
        check("misalign_code", rx_err_code, 2'b10);
        recover();

        // Single SE0 EOP.
        start_pkt();
        sb.push_back(mk(EV_VALID, 8'hA5, 0, 11'd1));
        send_byte(8'hA5, 1'b0);
        sb.push_back(mk(EV_ERROR, 0, 2'b10, 0));
        strobe(SE0); strobe(J);
        check("short_eop_code", rx_err_code, 2'b10);
        recover();

        // rx_enable drop mid-DATA without a strobe.
        start_pkt();
        sb.push_back(mk(EV_VALID, 8'h3C, 0, 11'd1));
        send_byte(8'h3C, 1'b0);
        strobe(K); strobe(J);
        rx_enable = 1'b0;
        cyc();
        check("dis_active", rx_active, 0);
        check("dis_det", det_reset, 1);
        check("dis_cnt", byte_count, 1);
        rx_enable = 1'b1;
        cyc();

`ifdef USB_RX_BABBLE_CHECK_EN
        // Babble: fifth byte exceeds the limit of four.
        start_pkt();
        for (int i = 1; i <= 4; i++)
            sb.push_back(mk(EV_VALID, 8'(8'h10 + i), 0, 11'(i)));
        sb.push_back(mk(EV_ERROR, 0, 2'b11, 0));
        for (int i = 1; i <= 5; i++)
            send_byte(8'(8'h10 + i), 1'b0);
        check("babble_code", rx_err_code, 2'b11);
        check("babble_cnt", byte_count, 4);
        recover();
`endif

        // Reset asserted mid-EOP.
        start_pkt();
        sb.push_back(mk(EV_VALID, 8'h5A, 0, 11'd1));
        send_byte(8'h5A, 1'b0);
        strobe(SE0);
        check("eop_active", rx_active, 1);
        reset = 1'b1;
        cyc();
        check_reset_vals("mid_rst");
        reset = 1'b0;
        repeat (4) cyc();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Receive-path sequencer for the USB PHY. It holds the line-level sync detector in reset until reception is enabled and watches for its sync flag. Once sync is flagged, it NRZI-decodes and bit-unstuffs the line, assembles LSB-first bytes and recognises EOP. Errors abort the packet, and the block re-arms the detector only after the bus returns to idle. It sits between the line sampler (bit strobe plus 2-bit line state) and the packet/SIE layer.

Parameters:
MAX_BYTES, 1027, babble limit in bytes per packet (used only with the optional feature)
IDLE_BITS, 8, consecutive J bit-times required to leave ABORT

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bit_strobe  input  1  one-clk pulse per USB bit time; line_state is valid when high
line_state  input  2  00 SE0, 01 J, 10 K, 11 SE1 (illegal)
rx_enable  input  1  level; reception is allowed while high
sync_detected  input  1  level from the sync detector; high once the full sync is seen
det_reset  output  1  reset to the sync detector
rx_active  output  1  high from sync accepted until EOP, error or disable
rx_data  output  8  assembled byte; valid while rx_valid is high
rx_valid  output  1  one-clk pulse per completed byte
rx_done  output  1  one-clk pulse on clean EOP
rx_error  output  1  one-clk pulse on entry to ABORT
rx_err_code  output  2  01 stuff error, 10 framing, 11 babble; held until next sync accept
byte_count  output  11  bytes received in the current or last packet

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, det_reset=1, rx_active=0, rx_data=0, rx_valid=0, rx_done=0, rx_error=0, rx_err_code=00, byte_count=0. Internal counters are cleared.
- All transitions are registered and, except for rx_enable deassertion, occur only on clocks with bit_strobe=1.
- det_reset=1 in IDLE and ABORT, 0 in WAIT_SYNC, DATA and EOP.
- IDLE: if rx_enable=1 -> WAIT_SYNC.
- WAIT_SYNC: if sync_detected=1 -> DATA.
  - Set rx_active=1 and prev_level=K.
  - Clear ones_cnt, bit_cnt, byte_count and rx_err_code.
- DATA, per strobe:
  - SE0 -> EOP with se0_cnt=1.
  - SE1 -> ABORT, code 10.
  - Otherwise decode bit = (line_state==prev_level), then set prev_level=line_state.
  - If ones_cnt==6: bit 0 is a stuff bit and is discarded (ones_cnt=0); bit 1 -> ABORT, code 01.
  - Else: shift the bit in at MSB (LSB-first assembly); ones_cnt = bit ? ones_cnt+1 : 0; bit_cnt++ mod 8.
  - When bit_cnt wraps 7->0: rx_data=assembled byte and rx_valid=1 on the next clk (latency 1 clk after the strobe); byte_count++ (saturates at 2047).
- EOP, per strobe:
  - SE0: se0_cnt++ (saturate 3).
  - J: if se0_cnt>=2 and bit_cnt==0 -> rx_done pulse, IDLE; else ABORT, code 10.
  - K or SE1: ABORT, code 10.
- Leaving DATA/EOP for any reason drops rx_active on the same clk the state changes.
- ABORT:
  - rx_error pulses on the entry clk; rx_err_code latched.
  - idle_cnt counts consecutive J strobes; any non-J clears it.
  - idle_cnt==IDLE_BITS -> IDLE.
- rx_enable=0 in any state: go to IDLE on the next clk regardless of strobe. rx_active drops, no rx_done/rx_error pulse, byte_count holds.
- Pulses (rx_valid, rx_done, rx_error) are exactly one clk wide and are mutually exclusive by construction.
- Reset mid-packet: immediate return to reset values at the next clk.

Optional Feature:
USB_RX_BABBLE_CHECK_EN
- Defined: a byte completing while byte_count==MAX_BYTES suppresses rx_valid -> ABORT, code 11.
- Undefined: no length limit; byte_count saturates at 2047 and reception continues.

Test Plan:
- rx_enable=1, sync_detected rises, then line K,J,J,K,J,J,K,K -> rx_valid once with rx_data=0xA5, byte_count=1. Follow with SE0,SE0,J -> rx_done pulse, rx_active 1->0, det_reset=1.
- Data 0xFF then 0x00: after six identical levels, one toggle (stuff) is inserted -> rx_data 0xFF then 0x00, stuff bit not counted. Drop the stuff toggle instead -> rx_error, rx_err_code=01, ABORT.
- SE1 mid-byte -> rx_error, code 10. Then 7 J strobes -> still ABORT (det_reset=1). Then 8th J -> IDLE, then WAIT_SYNC.
- SE0 after 3 bits of a byte, then SE0, J -> rx_error, code 10 (misaligned EOP), no rx_done. Single SE0 then J -> code 10.
- rx_enable deasserted mid-DATA without strobe -> IDLE next clk, rx_active=0, no pulses. Reset asserted mid-EOP -> all outputs at reset values next clk.
- With USB_RX_BABBLE_CHECK_EN and MAX_BYTES=4: send 5 bytes -> 4 rx_valid pulses, then rx_error, code 11.
